class_result_encoder: RTL and testbench

//  Consumer end of the classifier output stage. Accepts the one-hot class vector produced by the

---
 rtl/cnn_cls_pkg.sv | 19 +
 rtl/class_result_encoder_fifo.sv | 64 ++++++
 rtl/class_result_encoder.sv | 82 ++++++++
 tb/tb_class_result_encoder.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_cls_pkg.sv
// Shared classifier-output types and constants.
// Used by the result encoder and any later readout block.
package cnn_cls_pkg;

    localparam int N_CLASS = 10;
    localparam int IDX_W   = 4;

    // All-ones index marks an empty class vector.
    localparam logic [IDX_W-1:0] IDX_NONE = '1;

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic             tie;
        logic             none;
    } cls_result_t;

    localparam int RES_W = $bits(cls_result_t);

endpackage

// File: rtl/class_result_encoder_fifo.sv
// Generic synchronous FIFO with a registered head word.
// The head register is loaded on write-into-empty or on pop.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] rd_nxt;
    logic             load_din;

    assign rd_nxt = rd_ptr + 1'b1;

    // New head comes straight from din when the FIFO is (or becomes) empty.
    assign load_din = push &&
                      ((count == '0) || ((count == CNT_W'(1)) && pop));

    // Storage array; contents need no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers, occupancy and registered head.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            dout   <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_nxt;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (load_din) begin
                dout <= din;
            end else if (pop) begin
                dout <= mem[rd_nxt];
            end
        end
    end

endmodule

// File: rtl/class_result_encoder.sv
// Encodes one-hot class vectors to an index with tie/none flags,
// buffers results and keeps saturating frame/tie statistics.
module class_result_encoder
    import cnn_cls_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               oh_valid,
    output logic               oh_ready,
    input  logic [N_CLASS-1:0] oh_vec,
    output logic               idx_valid,
    input  logic               idx_ready,
    output logic [IDX_W-1:0]   idx,
    output logic               idx_tie,
    output logic               idx_none,
    output logic [CNT_W-1:0]   frame_count,
    output logic [CNT_W-1:0]   tie_count
);

    localparam int FCNT_W = $clog2(DEPTH) + 1;

    logic [FCNT_W-1:0] fifo_count;
    logic              push;
    logic              pop;
    cls_result_t       enc;
    logic [RES_W-1:0]  head_bits;
    cls_result_t       head;

    // Lowest set bit wins; a tie is any vector with a second bit set.
    always_comb begin
        enc.idx  = IDX_NONE;
        enc.none = (oh_vec == '0);
        enc.tie  = |(oh_vec & (oh_vec - 1'b1));
        for (int k = N_CLASS - 1; k >= 0; k--) begin
            if (oh_vec[k]) begin
                enc.idx = IDX_W'(k);
            end
        end
    end

    assign oh_ready  = !rst && (fifo_count != FCNT_W'(DEPTH));
    assign idx_valid = (fifo_count != '0);
    assign push      = oh_valid && oh_ready;
    assign pop       = idx_valid && idx_ready;

    sync_fifo #(
        .WIDTH (RES_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (enc),
        .pop   (pop),
        .dout  (head_bits),
        .count (fifo_count)
    );

    assign head     = cls_result_t'(head_bits);
    assign idx      = head.idx;
    assign idx_tie  = head.tie;
    assign idx_none = head.none;

    // Saturating statistics, bumped on each accepted vector.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_count <= '0;
            tie_count   <= '0;
        end else if (push) begin
            if (frame_count != '1) begin
                frame_count <= frame_count + 1'b1;
            end
            if (enc.tie && (tie_count != '1)) begin
                tie_count <= tie_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_class_result_encoder.sv
// Directed and random checks of class_result_encoder against a
// queue-based reference model; a narrow-counter twin checks saturation.
module tb_class_result_encoder;

    localparam int DEPTH = 4;

    typedef struct {
        int idx;
        bit tie;
        bit none;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       oh_valid;
    logic [9:0] oh_vec;
    logic       idx_ready;

    logic        oh_ready;
    logic        idx_valid;
    logic [3:0]  idx;
    logic        idx_tie;
    logic        idx_none;
    logic [15:0] frame_count;
    logic [15:0] tie_count;

    logic        s_oh_ready;
    logic        s_idx_valid;
    logic [3:0]  s_idx;
    logic        s_idx_tie;
    logic        s_idx_none;
    logic [2:0]  s_frame_count;
    logic [2:0]  s_tie_count;

    exp_t q[$];
    int   nfr;
    int   ntie;
    bit   fresh;
    int   ncmp;
    int   nfail;

    class_result_encoder #(.DEPTH(DEPTH), .CNT_W(16)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .oh_valid    (oh_valid),
        .oh_ready    (oh_ready),
        .oh_vec      (oh_vec),
        .idx_valid   (idx_valid),
        .idx_ready   (idx_ready),
        .idx         (idx),
        .idx_tie     (idx_tie),
        .idx_none    (idx_none),
        .frame_count (frame_count),
        .tie_count   (tie_count)
    );

    class_result_encoder #(.DEPTH(DEPTH), .CNT_W(3)) u_sat (
        .clk         (clk),
        .rst         (rst),
        .oh_valid    (oh_valid),
        .oh_ready    (s_oh_ready),
        .oh_vec      (oh_vec),
        .idx_valid   (s_idx_valid),
        .idx_ready   (idx_ready),
        .idx         (s_idx),
        .idx_tie     (s_idx_tie),
        .idx_none    (s_idx_none),
        .frame_count (s_frame_count),
        .tie_count   (s_tie_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(input logic [9:0] vec);
        exp_t e;
        int   v;
        v = int'(vec);
        if (v == 0) begin
            e.idx  = 15;
            e.none = 1'b1;
            e.tie  = 1'b0;
        end else begin
            e.idx  = $clog2(v & -v);
            e.none = 1'b0;
            e.tie  = ($countones(vec) > 1);
        end
        return e;
    endfunction

    function automatic int satv(input int n, input int m);
        return (n > m) ? m : n;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input bit r, input bit v,
                       input logic [9:0] vec, input bit rd);
        bit   do_push;
        bit   do_pop;
        exp_t e;
        @(negedge clk);
        rst       = r;
        oh_valid  = v;
        oh_vec    = vec;
        idx_ready = rd;
        #1;
        chk("oh_ready", 32'(oh_ready), 32'(!r && q.size() != DEPTH));
        chk("idx_valid", 32'(idx_valid), 32'(q.size() != 0));
        if (q.size() != 0) begin
            chk("idx", 32'(idx), 32'(q[0].idx));
            chk("idx_tie", 32'(idx_tie), 32'(q[0].tie));
            chk("idx_none", 32'(idx_none), 32'(q[0].none));
        end else if (fresh) begin
            chk("idx_rst", 32'({idx, idx_tie, idx_none}), 32'd0);
        end
        chk("frame_count", 32'(frame_count), 32'(satv(nfr, 65535)));
        chk("tie_count", 32'(tie_count), 32'(satv(ntie, 65535)));
        chk("sat_frame", 32'(s_frame_count), 32'(satv(nfr, 7)));
        chk("sat_tie", 32'(s_tie_count), 32'(satv(ntie, 7)));
        do_push = v && !r && (q.size() != DEPTH);
        do_pop  = !r && (q.size() != 0) && rd;
        @(posedge clk);
        if (r) begin
            q.delete();
            nfr   = 0;
            ntie  = 0;
            fresh = 1'b1;
        end else begin
            if (do_pop) begin
                void'(q.pop_front());
                fresh = 1'b0;
            end
            if (do_push) begin
                e = model(vec);
                q.push_back(e);
                nfr++;
                if (e.tie) ntie++;
                fresh = 1'b0;
            end
        end
    endtask

    initial begin
        logic [9:0] one;
        int         sel;
        logic [9:0] rv;
        ncmp      = 0;
        nfail     = 0;
        nfr       = 0;
        ntie      = 0;
        fresh     = 1'b1;
        rst       = 1'b1;
        oh_valid  = 1'b0;
        oh_vec    = '0;
        idx_ready = 1'b0;
        repeat (2) @(posedge clk);

        // single class 3
        cyc(0, 1, 10'b0000001000, 1);
        cyc(0, 0, '0, 1);

        // tie and empty vector
        cyc(0, 1, 10'b1000000010, 1);
        cyc(0, 1, 10'b0000000000, 1);
        cyc(0, 0, '0, 1);
        cyc(0, 0, '0, 1);

        // fill past depth with output stalled
        for (int k = 0; k < 5; k++) begin
            one = 10'd1 << k;
            cyc(0, 1, one, 0);
        end
        one = 10'd1 << 4;
        cyc(0, 1, one, 1);
        repeat (6) cyc(0, 0, '0, 1);

        // steady push+pop at two entries
        cyc(0, 1, 10'b0000100000, 0);
        cyc(0, 1, 10'b0001000000, 0);
        for (int k = 0; k < 8; k++) begin
            rv = 10'($urandom);
            cyc(0, 1, rv, 1);
        end
        repeat (3) cyc(0, 0, '0, 1);

        // reset with three entries buffered
        cyc(0, 1, 10'b0000000001, 0);
        cyc(0, 1, 10'b0000000110, 0);
        cyc(0, 1, 10'b1000000000, 0);
        cyc(1, 1, 10'b0000010000, 1);
        cyc(0, 0, '0, 0);

        // saturation on the narrow-counter twin
        for (int k = 0; k < 10; k++) begin
            cyc(0, 1, 10'b0000000011, 1);
        end
        repeat (2) cyc(0, 0, '0, 1);

        // random traffic
        for (int k = 0; k < 400; k++) begin
            sel = int'($urandom_range(0, 3));
            if (sel == 0) begin
                rv = '0;
            end else if (sel == 1) begin
                rv = 10'd1 << $urandom_range(0, 9);
            end else begin
                rv = 10'($urandom);
            end
            cyc(($urandom % 97) == 0, ($urandom % 4) != 0, rv,
                ($urandom % 3) != 0);
        end
        repeat (6) cyc(0, 0, '0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 ncmp, nfail);
        $finish;
    end

endmodule
